// File: rtl/bar_stream_tx_if.sv
// bar channel: 32-bit data/valid/ready stream between a transmitter (master)
// and a receiver (slave).
interface bar_stream_tx_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/bar_stream_tx.sv
// Transmitter end of the bar channel: small FIFO feeding a registered data/valid head.
// Optional accepted-word counter enabled by defining BAR_STREAM_TX_STATS_EN.
module bar_stream_tx #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_ready,
  bar_stream_tx_if.master          bar,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              tx_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_nx;
  logic [LW-1:0]    cnt;
  logic [LW-1:0]    cnt_nx;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             push;
  logic             pop;

  assign push      = push_valid && push_ready;
  assign pop       = valid_q && bar.ready;
  assign rd_ptr_nx = rd_ptr + AW'(1);

  always_comb begin
    cnt_nx = cnt;
    unique case ({push, pop})
      2'b10:   cnt_nx = cnt + LVL_ONE;
      2'b01:   cnt_nx = cnt - LVL_ONE;
      default: cnt_nx = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // The head word lives both in mem[rd_ptr] and in data_q; data_q is the
  // registered copy driven onto the channel so ready never reaches an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      push_ready <= 1'b1;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      valid_q    <= 1'b0;
      push_ready <= 1'b1;
    end else begin
      cnt        <= cnt_nx;
      push_ready <= (cnt_nx != LVL_FULL);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr_nx;
        if (cnt > LVL_ONE) begin
          data_q  <= mem[rd_ptr_nx];
          valid_q <= 1'b1;
        end else if (push) begin
          data_q  <= push_data;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (!valid_q && push) begin
        data_q  <= push_data;
        valid_q <= 1'b1;
      end
    end
  end

  assign bar.data  = data_q;
  assign bar.valid = valid_q;
  assign level     = cnt;

`ifdef BAR_STREAM_TX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_count <= '0;
    end else if (pop) begin
      tx_count <= tx_count + 32'd1;
    end
  end
`else
  assign tx_count = '0;
`endif

endmodule

// File: tb/tb_bar_stream_tx.sv
// Randomised and directed bench for bar_stream_tx against a queue-based reference model.
module tb_bar_stream_tx;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  push_valid;
  logic [WIDTH-1:0]      push_data;
  logic                  push_ready;
  logic [$clog2(DEPTH):0] level;
  logic [31:0]           tx_count;

  bar_stream_tx_if #(.WIDTH(WIDTH)) bus ();

  bar_stream_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .bar        (bus),
    .level      (level),
    .tx_count   (tx_count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model state
  logic [31:0] model_q[$];
  logic        model_pr;
  logic [31:0] model_txc;
  logic        model_data_known;
  logic [31:0] rx[$];

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock: update model from current inputs, then compare outputs.
  task automatic tick();
    logic do_pop;
    logic do_push;
    if (bus.valid && bus.ready) rx.push_back(bus.data);
    if (rst) begin
      model_q.delete();
      model_pr         = 1'b1;
      model_txc        = '0;
      model_data_known = 1'b1;
    end else if (flush) begin
      model_q.delete();
      model_pr         = 1'b1;
      model_data_known = 1'b0;
    end else begin
      do_pop  = (model_q.size() > 0) && bus.ready;
      do_push = push_valid && model_pr;
      if (do_pop) begin
        void'(model_q.pop_front());
        model_txc = model_txc + 32'd1;
      end
      if (do_push) model_q.push_back(push_data);
      model_pr = (model_q.size() != DEPTH);
      if (do_pop || do_push) model_data_known = 1'b0;
    end
    prev_valid = bus.valid;
    prev_ready = bus.ready;
    prev_data  = bus.data;
    @(posedge clk);
    #1;
    check("valid", {31'd0, bus.valid}, {31'd0, model_q.size() > 0});
    check("level", 32'(level), model_q.size());
    check("push_ready", {31'd0, push_ready}, {31'd0, model_pr});
    if (model_q.size() > 0) check("data", bus.data, model_q[0]);
    else if (model_data_known) check("data_reset", bus.data, 32'd0);
`ifdef BAR_STREAM_TX_STATS_EN
    check("tx_count", tx_count, model_txc);
`else
    check("tx_count", tx_count, 32'd0);
`endif
    if (prev_valid && !prev_ready && !rst && !flush) check("hold", bus.data, prev_data);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0;
  endtask

  initial begin
    int unsigned next_w;
    int unsigned bad;
    int unsigned budget;
    logic accepted;

    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0; bus.ready = 1'b0;
    model_q.delete(); model_pr = 1'b1; model_txc = '0; model_data_known = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_push_ready", {31'd0, push_ready}, 32'd1);
    idle_inputs();

    // Single word latency and retire
    bus.ready = 1'b1; push_valid = 1'b1; push_data = 32'hA5A5_0001;
    tick();
    check("lat_valid", {31'd0, bus.valid}, 32'd1);
    check("lat_data", bus.data, 32'hA5A5_0001);
    push_valid = 1'b0;
    tick();
    check("ret_valid", {31'd0, bus.valid}, 32'd0);
    check("ret_level", 32'(level), 32'd0);

    // Fill with ready low, hold for 10 cycles, then drain back-to-back
    rx.delete();
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = 32'h11 * (i + 1);
      tick();
    end
    push_valid = 1'b0;
    check("full_level", 32'(level), 32'd4);
    check("full_push_ready", {31'd0, push_ready}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      bus.ready = (i % 3 == 1);
      bus.ready = 1'b0;
      tick();
      check("hold_11", bus.data, 32'h11);
    end
    bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("drain_count", rx.size(), 32'd4);
    for (int i = 0; i < 4; i++) if (i < rx.size()) check("drain_word", rx[i], 32'h11 * (i + 1));

    // Full FIFO with simultaneous pop and push: push must be rejected
    rx.delete();
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_valid = 1'b1; push_data = 32'h100 + i;
      tick();
    end
    bus.ready = 1'b1; push_valid = 1'b1; push_data = 32'h555;
    tick();
    check("rej_level", 32'(level), 32'd3);
    check("rej_push_ready", {31'd0, push_ready}, 32'd1);
    push_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rej_count", rx.size(), 32'd4);
    for (int i = 0; i < 4; i++) if (i < rx.size()) check("rej_word", rx[i], 32'h100 + i);

    // Random ready toggling, 1000 incrementing words
    rx.delete();
    next_w = 0;
    budget = 0;
    while (next_w < 1000 && budget < 20000) begin
      push_valid = ($urandom_range(0, 3) != 0);
      push_data  = next_w;
      bus.ready  = $urandom_range(0, 1);
      accepted   = push_valid && push_ready;
      tick();
      if (accepted) next_w++;
      budget++;
    end
    check("rand_budget", {31'd0, budget < 20000}, 32'd1);
    push_valid = 1'b0; bus.ready = 1'b1;
    budget = 0;
    while (bus.valid && budget < 20) begin
      tick();
      budget++;
    end
    check("rand_drained", {31'd0, bus.valid}, 32'd0);
    check("rand_count", rx.size(), 32'd1000);
    bad = 0;
    foreach (rx[i]) if (rx[i] != i) bad++;
    check("rand_order", bad, 32'd0);

    // Flush with 3 queued words and a push in the flush cycle
    rx.delete();
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 32'h200 + i;
      tick();
    end
    flush = 1'b1; push_valid = 1'b1; push_data = 32'hDEAD_BEEF;
    tick();
    check("flush_valid", {31'd0, bus.valid}, 32'd0);
    check("flush_level", 32'(level), 32'd0);
    flush = 1'b0; push_valid = 1'b0; bus.ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("flush_rx", rx.size(), 32'd0);

`ifdef BAR_STREAM_TX_STATS_EN
    force dut.tx_count = 32'hFFFF_FFFE;
    #1;
    release dut.tx_count;
    model_txc = 32'hFFFF_FFFE;
`endif
    bus.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_data = 32'h300 + i;
      tick();
    end
    push_valid = 1'b0;
    tick();
`ifdef BAR_STREAM_TX_STATS_EN
    check("stats_wrap", tx_count, 32'h0000_0001);
`else
    check("stats_off", tx_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
